// File: rtl/mem_stage_if.sv
// Pipeline bundle between ALU, mem_stage, data memory and writeback.
// The slave modport is the mem_stage view; master is the surrounding pipeline/memory.
interface mem_stage_if #(
    parameter int XLEN = 32
);
    logic            valid_in;
    logic [11:0]     operation;
    logic [XLEN-1:0] alu_out;
    logic            zero;
    logic [XLEN-1:0] store_data;
    logic [4:0]      rd_in;
    logic            stall_out;
    logic            dmem_req;
    logic            dmem_we;
    logic [XLEN-1:0] dmem_addr;
    logic [XLEN-1:0] dmem_wdata;
    logic [3:0]      dmem_wstrb;
    logic            dmem_ready;
    logic [XLEN-1:0] dmem_rdata;
    logic            wb_valid;
    logic            wb_we;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            branch_taken;
    logic            misaligned;

    modport slave (
        input  valid_in, operation, alu_out, zero, store_data, rd_in,
        input  dmem_ready, dmem_rdata,
        output stall_out, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
        output wb_valid, wb_we, wb_rd, wb_data, branch_taken, misaligned
    );

    modport master (
        output valid_in, operation, alu_out, zero, store_data, rd_in,
        output dmem_ready, dmem_rdata,
        input  stall_out, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
        input  wb_valid, wb_we, wb_rd, wb_data, branch_taken, misaligned
    );
endinterface

// File: rtl/mem_stage.sv
// Memory stage: loads/stores via a ready-handshaked port, registers the writeback record.
// Latency 1 for non-memory ops, 2+N for memory ops; stall_out (registered) blocks upstream while waiting.
module mem_stage #(
    parameter int XLEN = 32
) (
    input  logic      clk,
    input  logic      reset,
    mem_stage_if.slave bus
);
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [1:0]      off_q, off_d;
    logic [2:0]      f3_q, f3_d;
    logic [4:0]      rd_q, rd_d;
    logic            we_q, we_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [3:0]      wstrb_q, wstrb_d;
    logic            wb_valid_q, wb_valid_d;
    logic            wb_we_q, wb_we_d;
    logic [4:0]      wb_rd_q, wb_rd_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;
    logic            branch_q, branch_d;
    logic            mis_q, mis_d;

    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic            is_load, is_store, is_byte, is_half, is_word, is_mis, writes_rd;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] ld_ext;
    logic            unused_op_bits;

    assign opcode         = bus.operation[6:0];
    assign f3             = bus.operation[9:7];
    assign unused_op_bits = ^bus.operation[11:10];
    assign is_load        = (opcode == OP_LOAD);
    assign is_store       = (opcode == OP_STORE);
    // Undefined funct3 falls back to word size; 100/101 are only byte/half for loads.
    assign is_byte   = (f3 == 3'b000) || (is_load && f3 == 3'b100);
    assign is_half   = (f3 == 3'b001) || (is_load && f3 == 3'b101);
    assign is_word   = !is_byte && !is_half;
    assign is_mis    = (is_half && bus.alu_out[0]) || (is_word && (bus.alu_out[1:0] != 2'b00));
    assign writes_rd = (opcode == OP_REG) || (opcode == OP_IMM) || (opcode == OP_JAL)
                    || (opcode == OP_JALR) || (opcode == OP_AUIPC);

    assign ld_byte = bus.dmem_rdata[{off_q, 3'b000} +: 8];
    assign ld_half = bus.dmem_rdata[{off_q[1], 4'b0000} +: 16];

    always_comb begin
        ld_ext = bus.dmem_rdata;
        case (f3_q)
            3'b000:  ld_ext = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{(XLEN-16){ld_half[15]}}, ld_half};
            3'b100:  ld_ext = {{(XLEN-8){1'b0}}, ld_byte};
            3'b101:  ld_ext = {{(XLEN-16){1'b0}}, ld_half};
            default: ld_ext = bus.dmem_rdata;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        off_d      = off_q;
        f3_d       = f3_q;
        rd_d       = rd_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        wb_valid_d = 1'b0;
        wb_we_d    = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        branch_d   = 1'b0;
        mis_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.valid_in) begin
                    if ((is_load || is_store) && !is_mis) begin
                        state_d = WAIT;
                        addr_d  = {bus.alu_out[XLEN-1:2], 2'b00};
                        off_d   = bus.alu_out[1:0];
                        f3_d    = f3;
                        rd_d    = bus.rd_in;
                        we_d    = is_store;
                        wdata_d = '0;
                        wstrb_d = 4'b0000;
                        if (is_store) begin
                            if (is_byte) begin
                                wdata_d = {(XLEN/8){bus.store_data[7:0]}};
                                wstrb_d = 4'b0001 << bus.alu_out[1:0];
                            end else if (is_half) begin
                                wdata_d = {(XLEN/16){bus.store_data[15:0]}};
                                wstrb_d = 4'b0011 << bus.alu_out[1:0];
                            end else begin
                                wdata_d = bus.store_data;
                                wstrb_d = 4'b1111;
                            end
                        end
                    end else begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = bus.rd_in;
                        wb_data_d  = bus.alu_out;
                        mis_d      = is_load || is_store;
                        wb_we_d    = writes_rd && (bus.rd_in != 5'd0);
                        branch_d   = (opcode == OP_BRANCH) && bus.zero;
                    end
                end
            end
            WAIT: begin
                if (bus.dmem_ready) begin
                    state_d    = IDLE;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    if (!we_q) begin
                        wb_we_d   = (rd_q != 5'd0);
                        wb_data_d = ld_ext;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            off_q      <= 2'b00;
            f3_q       <= 3'b000;
            rd_q       <= 5'd0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            wstrb_q    <= 4'b0000;
            wb_valid_q <= 1'b0;
            wb_we_q    <= 1'b0;
            wb_rd_q    <= 5'd0;
            wb_data_q  <= '0;
            branch_q   <= 1'b0;
            mis_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            off_q      <= off_d;
            f3_q       <= f3_d;
            rd_q       <= rd_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            wb_valid_q <= wb_valid_d;
            wb_we_q    <= wb_we_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            branch_q   <= branch_d;
            mis_q      <= mis_d;
        end
    end

    // Request-side outputs read as zero whenever no access is outstanding.
    assign bus.stall_out    = (state_q == WAIT);
    assign bus.dmem_req     = (state_q == WAIT);
    assign bus.dmem_we      = (state_q == WAIT) && we_q;
    assign bus.dmem_addr    = (state_q == WAIT) ? addr_q  : '0;
    assign bus.dmem_wdata   = (state_q == WAIT) ? wdata_q : '0;
    assign bus.dmem_wstrb   = (state_q == WAIT) ? wstrb_q : 4'b0000;
    assign bus.wb_valid     = wb_valid_q;
    assign bus.wb_we        = wb_we_q;
    assign bus.wb_rd        = wb_rd_q;
    assign bus.wb_data      = wb_data_q;
    assign bus.branch_taken = branch_q;
    assign bus.misaligned   = mis_q;
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: reset, ALU passthrough, loads, stores, misalign, branch, reset abort.
module tb_mem_stage;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    mem_stage_if #(.XLEN(32)) bus ();

    mem_stage #(.XLEN(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] op(input logic [2:0] f3, input logic [6:0] opc);
        return {2'b00, f3, opc};
    endfunction

    task automatic issue(input logic [11:0] oper, input logic [31:0] alu, input logic z,
                         input logic [31:0] sdata, input logic [4:0] rd);
        bus.valid_in   = 1'b1;
        bus.operation  = oper;
        bus.alu_out    = alu;
        bus.zero       = z;
        bus.store_data = sdata;
        bus.rd_in      = rd;
        step();
        bus.valid_in   = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".stall"},  {31'd0, bus.stall_out}, 32'd0);
        check({tag, ".req"},    {31'd0, bus.dmem_req}, 32'd0);
        check({tag, ".wbv"},    {31'd0, bus.wb_valid}, 32'd0);
        check({tag, ".wbwe"},   {31'd0, bus.wb_we}, 32'd0);
        check({tag, ".wbdata"}, bus.wb_data, 32'd0);
        check({tag, ".br"},     {31'd0, bus.branch_taken}, 32'd0);
        check({tag, ".mis"},    {31'd0, bus.misaligned}, 32'd0);
    endtask

    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] exp);
        issue(op(f3, 7'b0000011), 32'h0000_0103, 1'b0, 32'd0, 5'd7);
        bus.dmem_ready = 1'b0;
        check({tag, ".req1"},  {31'd0, bus.dmem_req}, 32'd1);
        check({tag, ".stl1"},  {31'd0, bus.stall_out}, 32'd1);
        check({tag, ".addr1"}, bus.dmem_addr, 32'h0000_0100);
        check({tag, ".we"},    {31'd0, bus.dmem_we}, 32'd0);
        step();
        check({tag, ".stl2"},  {31'd0, bus.stall_out}, 32'd1);
        check({tag, ".addr2"}, bus.dmem_addr, 32'h0000_0100);
        step();
        check({tag, ".stl3"},  {31'd0, bus.stall_out}, 32'd1);
        check({tag, ".addr3"}, bus.dmem_addr, 32'h0000_0100);
        check({tag, ".nowb"},  {31'd0, bus.wb_valid}, 32'd0);
        bus.dmem_ready = 1'b1;
        bus.dmem_rdata = 32'h80FF_FF12;
        step();
        bus.dmem_ready = 1'b0;
        bus.dmem_rdata = 32'd0;
        check({tag, ".wbv"},   {31'd0, bus.wb_valid}, 32'd1);
        check({tag, ".wbwe"},  {31'd0, bus.wb_we}, 32'd1);
        check({tag, ".wbrd"},  {27'd0, bus.wb_rd}, 32'd7);
        check({tag, ".data"},  bus.wb_data, exp);
        check({tag, ".stl4"},  {31'd0, bus.stall_out}, 32'd0);
        check({tag, ".req4"},  {31'd0, bus.dmem_req}, 32'd0);
        step();
        check({tag, ".pulse"}, {31'd0, bus.wb_valid}, 32'd0);
    endtask

    initial begin
        reset          = 1'b1;
        bus.valid_in   = 1'b0;
        bus.operation  = '0;
        bus.alu_out    = '0;
        bus.zero       = 1'b0;
        bus.store_data = '0;
        bus.rd_in      = '0;
        bus.dmem_ready = 1'b0;
        bus.dmem_rdata = '0;
        step();
        step();
        check_all_zero("rst0");
        reset = 1'b0;

        // Reset mid-stream with valid_in still high
        issue(op(3'b000, 7'b0110011), 32'h0000_0055, 1'b0, 32'd0, 5'd3);
        check("pre_rst.wbv", {31'd0, bus.wb_valid}, 32'd1);
        bus.valid_in = 1'b1;
        reset = 1'b1;
        step();
        step();
        check_all_zero("rst1");
        bus.valid_in = 1'b0;
        reset = 1'b0;
        step();

        // ALU passthrough
        issue(op(3'b000, 7'b0110011), 32'h0000_002A, 1'b0, 32'd0, 5'd5);
        check("add.wbv",  {31'd0, bus.wb_valid}, 32'd1);
        check("add.wbwe", {31'd0, bus.wb_we}, 32'd1);
        check("add.rd",   {27'd0, bus.wb_rd}, 32'd5);
        check("add.data", bus.wb_data, 32'h0000_002A);
        issue(op(3'b000, 7'b0110011), 32'h0000_0033, 1'b0, 32'd0, 5'd0);
        check("add0.wbv",  {31'd0, bus.wb_valid}, 32'd1);
        check("add0.wbwe", {31'd0, bus.wb_we}, 32'd0);
        check("add0.data", bus.wb_data, 32'h0000_0033);
        step();
        check("add.pulse", {31'd0, bus.wb_valid}, 32'd0);

        // Loads
        do_load("lb",  3'b000, 32'hFFFF_FF80);
        do_load("lbu", 3'b100, 32'h0000_0080);

        // Store halfword
        issue(op(3'b001, 7'b0100011), 32'h0000_0202, 1'b0, 32'h1234_ABCD, 5'd9);
        check("sh.req",   {31'd0, bus.dmem_req}, 32'd1);
        check("sh.we",    {31'd0, bus.dmem_we}, 32'd1);
        check("sh.addr",  bus.dmem_addr, 32'h0000_0200);
        check("sh.wdata", bus.dmem_wdata, 32'hABCD_ABCD);
        check("sh.wstrb", {28'd0, bus.dmem_wstrb}, 32'hC);
        bus.dmem_ready = 1'b1;
        step();
        bus.dmem_ready = 1'b0;
        check("sh.wbv",  {31'd0, bus.wb_valid}, 32'd1);
        check("sh.wbwe", {31'd0, bus.wb_we}, 32'd0);
        check("sh.req2", {31'd0, bus.dmem_req}, 32'd0);

        // Store byte
        issue(op(3'b000, 7'b0100011), 32'h0000_0201, 1'b0, 32'h0000_00EF, 5'd9);
        check("sb.wdata", bus.dmem_wdata, 32'hEFEF_EFEF);
        check("sb.wstrb", {28'd0, bus.dmem_wstrb}, 32'h2);
        bus.dmem_ready = 1'b1;
        step();
        bus.dmem_ready = 1'b0;
        check("sb.wbv", {31'd0, bus.wb_valid}, 32'd1);

        // Misaligned word load
        issue(op(3'b010, 7'b0000011), 32'h0000_0101, 1'b0, 32'd0, 5'd4);
        check("mis.req",  {31'd0, bus.dmem_req}, 32'd0);
        check("mis.stl",  {31'd0, bus.stall_out}, 32'd0);
        check("mis.flag", {31'd0, bus.misaligned}, 32'd1);
        check("mis.wbv",  {31'd0, bus.wb_valid}, 32'd1);
        check("mis.wbwe", {31'd0, bus.wb_we}, 32'd0);
        step();
        check("mis.pulse", {31'd0, bus.misaligned}, 32'd0);
        check("mis.req2",  {31'd0, bus.dmem_req}, 32'd0);

        // Branch
        issue(op(3'b000, 7'b1100011), 32'h0000_0001, 1'b1, 32'd0, 5'd6);
        check("beq.br",   {31'd0, bus.branch_taken}, 32'd1);
        check("beq.wbwe", {31'd0, bus.wb_we}, 32'd0);
        step();
        check("beq.pulse", {31'd0, bus.branch_taken}, 32'd0);

        // Reset during WAIT abandons the access
        issue(op(3'b010, 7'b0000011), 32'h0000_0300, 1'b0, 32'd0, 5'd8);
        check("abort.req", {31'd0, bus.dmem_req}, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort.req2", {31'd0, bus.dmem_req}, 32'd0);
        check("abort.stl",  {31'd0, bus.stall_out}, 32'd0);
        bus.dmem_ready = 1'b1;
        bus.dmem_rdata = 32'hDEAD_BEEF;
        step();
        bus.dmem_ready = 1'b0;
        check("abort.wbv",  {31'd0, bus.wb_valid}, 32'd0);
        check("abort.req3", {31'd0, bus.dmem_req}, 32'd0);
        check("abort.data", bus.wb_data, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the fewcore pipeline, directly downstream of the ALU. It consumes the ALU's registered result (`alu_out`, `zero`) together with the aligned `operation` word and store data. It performs loads and stores through a ready-handshaked data-memory port, sign- or zero-extends load data, and registers the writeback record. That record also serves as the ALU's `forward` source.

## Interface
Parameters:
- XLEN, 32, datapath width.

Ports:
- clk  in  1  Single clock; all state updates on its rising edge.
- reset  in  1  Synchronous, active-high; sampled on rising clk.
- valid_in  in  1  Upstream presents an instruction this cycle.
- operation  in  12  Same encoding as the ALU. `[6:0]` is the opcode; `[9:7]` is funct3. Aligned with `alu_out`.
- alu_out  in  XLEN  ALU result; the effective address for loads and stores.
- zero  in  1  ALU branch-condition result.
- store_data  in  XLEN  rs2 value for stores.
- rd_in  in  5  Destination register.
- stall_out  out  1  High while a memory access is outstanding. Upstream holds its outputs stable while this is high.
- dmem_req  out  1  Data-memory request.
- dmem_we  out  1  1 = store, 0 = load.
- dmem_addr  out  XLEN  Word-aligned address, `{alu_out[XLEN-1:2], 2'b00}`.
- dmem_wdata  out  XLEN  Store data, lane-replicated.
- dmem_wstrb  out  4  Byte strobes.
- dmem_ready  in  1  Memory completes the request this cycle.
- dmem_rdata  in  XLEN  Load word; valid when dmem_ready is high.
- wb_valid  out  1  Writeback record valid (one-cycle pulse).
- wb_we  out  1  Register-file write enable.
- wb_rd  out  5  Writeback register.
- wb_data  out  XLEN  Writeback value; also drives the ALU's `forward` input.
- branch_taken  out  1  Registered `zero` for branch opcodes.
- misaligned  out  1  One-cycle pulse flagging a misaligned access.

## Operation
- **FSM states:** IDLE and WAIT.
- **IDLE, valid_in low:** no request is issued. All pulse outputs (wb_valid, wb_we, branch_taken, misaligned) are 0 in the following cycle.
- **IDLE, valid_in high, non-memory opcode:**
  - Next cycle: wb_valid=1, wb_data=alu_out, wb_rd=rd_in.
  - wb_we=1 for opcodes 0110011, 0010011, 1101111, 1100111, 0010111 when rd_in≠0; otherwise wb_we=0.
  - For opcode 1100011, branch_taken=zero and wb_we=0.
- **IDLE, valid_in high, load (0000011) or store (0100011), aligned:**
  - Latch the address, funct3, rd_in and store data.
  - Next cycle: dmem_req=1 and the FSM enters WAIT.
- **Misaligned access:** halfword with addr[0]=1, or word with addr[1:0]≠0.
  - No request is issued; the FSM stays in IDLE.
  - Next cycle: misaligned=1, wb_valid=1, wb_we=0.
- **WAIT:**
  - dmem_req, dmem_we, dmem_addr, dmem_wdata and dmem_wstrb are held stable until dmem_ready is sampled high.
  - On that edge the FSM returns to IDLE and dmem_req drops.
  - For a load, the writeback record is registered on that same edge with wb_we=(rd≠0).
  - For a store, wb_valid=1 and wb_we=0.
- **Load extension** (byte/half selected by addr[1:0]):
  - lb (000): sign-extend the selected byte.
  - lh (001): sign-extend the selected halfword.
  - lw (010): whole word.
  - lbu (100): zero-extend the selected byte.
  - lhu (101): zero-extend the selected halfword.
- **Store lanes:**
  - sb: wdata = {4{byte}}, wstrb = 4'b0001<<addr[1:0].
  - sh: wdata = {2{half}}, wstrb = 4'b0011<<addr[1:0].
  - sw: wstrb = 4'b1111.
- **Undefined funct3** on a load or store: treated as lw/sw respectively.
- **stall_out** = (state==WAIT). It is registered, with no combinational path from dmem_ready.
- **Reset:**
  - State goes to IDLE; every output is 0.
  - Reset during WAIT abandons the access, and dmem_req is 0 the next cycle.
  - A dmem_ready seen in IDLE is ignored.

## Timing
- **Non-memory instruction:** latency 1 cycle from valid_in to wb_valid.
- **Memory access:** latency 2+N cycles. Request is issued at T+1. If dmem_ready is high at T+1+N, wb_valid is asserted at T+2+N. The minimum, with ready in the first request cycle, is 2.
- **Throughput:** one non-memory instruction per cycle. A memory access blocks acceptance until the cycle after completion.
- valid_in is ignored while in WAIT.
- wb_* outputs, branch_taken and misaligned are pulses lasting exactly one cycle per accepted instruction.

## Test plan
- **Reset:** assert reset for 2 cycles mid-stream. Required: all outputs 0, stall_out=0, no request issued.
- **ALU passthrough:** add, rd=5, alu_out=0x0000_002A. Required: one cycle later wb_valid=1, wb_we=1, wb_rd=5, wb_data=0x2A. Repeat with rd=0: wb_we=0.
- **Load:** lb at alu_out=0x103, dmem_ready=1 on the 3rd request cycle, rdata=0x80FF_FF12. Required: stall_out high for 3 cycles, dmem_addr=0x100 held stable, wb_data=0xFFFF_FF80. Repeat as lbu: wb_data=0x80.
- **Store:** sh at 0x202, store_data=0x1234_ABCD. Required: dmem_we=1, wdata=0xABCD_ABCD, wstrb=4'b1100, wb_we=0.
- **Misaligned:** lw at 0x101. Required: no dmem_req, misaligned=1 for one cycle, wb_we=0.
- **Branch and reset-abort:**
  - beq with zero=1. Required: branch_taken=1 for one cycle.
  - Reset asserted during WAIT. Required: dmem_req=0 next cycle, FSM in IDLE, a late dmem_ready produces no wb_valid.
